pcbfpga_cfg_slice: RTL and testbench

Runtime-configurable logic slice: N cells, each a K-input LUT followed by an optional flip-flop. Unlike fixed-parameter LUT/FF primitives, the LUT INIT and FF mode bits are loaded serially through a configuration shift chain, controlled by a small load FSM. Slices can be daisy-chained via CFG_DOUT to build a board-level bitstream chain. This is the next-generation logic element of the PCB FPGA fabric.

---
 rtl/pcbfpga_pkg.sv | 27 ++
 rtl/pcbfpga_cell.sv | 70 +++++++
 rtl/pcbfpga_cfg_slice.sv | 125 ++++++++++++
 tb/tb_pcbfpga_cfg_slice.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcbfpga_pkg.sv
// Shared types and sizing helpers for the configurable logic slice.
package pcbfpga_pkg;

   // Load sequencer states: empty chain, chain partially shifted, fabric running.
   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } cfg_state_e;

   // Mode-bit positions, relative to the end of the LUT INIT field.
   localparam int OFF_NO_ENABLE  = 0;
   localparam int OFF_HAS_RESET  = 1;
   localparam int OFF_ACTIVE_LOW = 2;
   localparam int OFF_REGISTERED = 3;

   // Config bits per cell: LUT truth table plus four mode bits.
   function automatic int cfg_cell_width(input int k);
      return (2 ** k) + 4;
   endfunction

   // Full chain length of a slice.
   function automatic int cfg_total(input int k, input int n);
      return n * cfg_cell_width(k);
   endfunction

endpackage

// File: rtl/pcbfpga_cell.sv
// One logic cell: K-input LUT with an optional flip-flop behind it.
// Mode bits come from the slice's config chain; run gates all FF activity.
module pcbfpga_cell
   import pcbfpga_pkg::*;
#(
   parameter int K  = 4,
   parameter int CW = cfg_cell_width(K)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic [CW-1:0] cfg,
   input  logic [K-1:0]  i,
   input  logic          ce,
   input  logic          sr,
   output logic          o
);

   localparam int LUT_SIZE = 2 ** K;

   logic [LUT_SIZE-1:0] init_s;
   logic                no_enable_s;
   logic                has_reset_s;
   logic                active_low_s;
   logic                registered_s;
   logic                f_s;
   logic                active_s;
   logic                rst_cond_s;
   logic                q_r;

   assign init_s       = cfg[LUT_SIZE-1:0];
   assign no_enable_s  = cfg[LUT_SIZE + OFF_NO_ENABLE];
   assign has_reset_s  = cfg[LUT_SIZE + OFF_HAS_RESET];
   assign active_low_s = cfg[LUT_SIZE + OFF_ACTIVE_LOW];
   assign registered_s = cfg[LUT_SIZE + OFF_REGISTERED];

   assign f_s        = init_s[i];
   assign active_s   = ce | no_enable_s;
   assign rst_cond_s = has_reset_s & (sr ^ active_low_s);

   // Cell flip-flop: cleared outside RUN; the reset condition only acts when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= 1'b0;
      end else if (!run) begin
         q_r <= 1'b0;
      end else if (active_s && rst_cond_s) begin
         q_r <= 1'b0;
      end else if (active_s) begin
         q_r <= f_s;
      end else begin
         q_r <= q_r;
      end
   end

   // Output select: registered or direct LUT value, forced low until configured.
   always_comb begin
      o = 1'b0;
      if (run) begin
         if (registered_s) begin
            o = q_r;
         end else begin
            o = f_s;
         end
      end else begin
         o = 1'b0;
      end
   end

endmodule

// File: rtl/pcbfpga_cfg_slice.sv
// Configurable logic slice: N LUT/FF cells whose INIT and mode bits are
// shifted in serially. CFG_DOUT lets several slices form one long chain.
module pcbfpga_cfg_slice
   import pcbfpga_pkg::*;
#(
   parameter int K = 4,
   parameter int N = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           CFG_EN,
   input  logic           CFG_DIN,
   output logic           CFG_DOUT,
   output logic           CFG_DONE,
   input  logic [N*K-1:0] I,
   input  logic [N-1:0]   CE,
   input  logic [N-1:0]   SR,
   output logic [N-1:0]   O
);

   localparam int CW    = cfg_cell_width(K);
   localparam int TOTAL = cfg_total(K, N);
   localparam int CNTW  = $clog2(TOTAL + 1);
   localparam logic [CNTW-1:0] LAST_IDX = CNTW'(TOTAL - 1);

   cfg_state_e       state_r;
   cfg_state_e       state_nxt_s;
   logic [CNTW-1:0]  cnt_r;
   logic [TOTAL-1:0] cfg_r;
   logic             done_r;
   logic             shift_s;
   logic             last_s;
   logic             run_s;

   // Load sequencer: decides whether this edge shifts and when the chain is full.
   always_comb begin
      state_nxt_s = state_r;
      shift_s     = 1'b0;
      last_s      = 1'b0;
      case (state_r)
         UNCFG: begin
            if (CFG_EN) begin
               shift_s     = 1'b1;
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = UNCFG;
            end
         end
         LOAD: begin
            if (CFG_EN) begin
               shift_s = 1'b1;
               if (cnt_r == LAST_IDX) begin
                  last_s      = 1'b1;
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = LOAD;
               end
            end else begin
               state_nxt_s = LOAD;
            end
         end
         RUN: begin
            state_nxt_s = RUN;
         end
         default: begin
            state_nxt_s = UNCFG;
         end
      endcase
   end

   // Sequencer state register; RUN is left only through RST.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= UNCFG;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Config shift chain and bit counter; both hold while CFG_EN is low or in RUN.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cfg_r <= '0;
         cnt_r <= '0;
      end else if (shift_s) begin
         cfg_r <= {cfg_r[TOTAL-2:0], CFG_DIN};
         cnt_r <= cnt_r + CNTW'(1);
      end else begin
         cfg_r <= cfg_r;
         cnt_r <= cnt_r;
      end
   end

   // Done flag: set by the edge that shifts the final chain bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         done_r <= 1'b0;
      end else if (last_s) begin
         done_r <= 1'b1;
      end else begin
         done_r <= done_r;
      end
   end

   assign CFG_DOUT = cfg_r[TOTAL-1];
   assign CFG_DONE = done_r;
   assign run_s    = (state_r == RUN);

   for (genvar c = 0; c < N; c++) begin : g_cell
      pcbfpga_cell #(
         .K (K),
         .CW(CW)
      ) u_cell (
         .clk(CLK),
         .rst(RST),
         .run(run_s),
         .cfg(cfg_r[c*CW +: CW]),
         .i  (I[c*K +: K]),
         .ce (CE[c]),
         .sr (SR[c]),
         .o  (O[c])
      );
   end

endmodule

// File: tb/tb_pcbfpga_cfg_slice.sv
// Self-checking bench for pcbfpga_cfg_slice with K=4, N=2 (40-bit chain).
module tb_pcbfpga_cfg_slice;

   localparam int K     = 4;
   localparam int N     = 2;
   localparam int TOTAL = 40;

   // cell1 {REG,AL,HR,NE}, cell1 INIT, cell0 mode, cell0 INIT
   localparam logic [TOTAL-1:0] VEC2 = {4'b1001, 16'h6996, 4'b0000, 16'h8000};
   localparam logic [TOTAL-1:0] VEC4 = {4'b1110, 16'h6996, 4'b0000, 16'h8000};

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           CFG_EN = 1'b0;
   logic           CFG_DIN = 1'b0;
   logic           CFG_DOUT;
   logic           CFG_DONE;
   logic [N*K-1:0] I = '0;
   logic [N-1:0]   CE = '0;
   logic [N-1:0]   SR = '0;
   logic [N-1:0]   O;

   int         tests_run = 0;
   int         tests_failed = 0;
   logic [1:0] exp_q[$];
   logic [1:0] exp_o;

   pcbfpga_cfg_slice #(.K(K), .N(N)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .CFG_EN  (CFG_EN),
      .CFG_DIN (CFG_DIN),
      .CFG_DOUT(CFG_DOUT),
      .CFG_DONE(CFG_DONE),
      .I       (I),
      .CE      (CE),
      .SR      (SR),
      .O       (O)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   // Shift a full stream MSB-first, optionally pausing CFG_EN mid-way.
   task automatic load_stream(input logic [TOTAL-1:0] vec, input int pause_after,
                              input int pause_len, input string tag);
      for (int j = 0; j < TOTAL; j++) begin
         if (j == pause_after) begin
            CFG_EN = 1'b0;
            repeat (pause_len) step();
            tests_run++;
            if (CFG_DONE !== 1'b0) begin
               tests_failed++;
               $display("FAIL %s_done_in_pause: CFG_DONE=%b expected 0", tag, CFG_DONE);
            end
         end
         CFG_EN  = 1'b1;
         CFG_DIN = vec[TOTAL-1-j];
         if (j == TOTAL - 1) begin
            tests_run++;
            if (CFG_DONE !== 1'b0) begin
               tests_failed++;
               $display("FAIL %s_done_early: CFG_DONE=%b expected 0 after 39 shifts", tag, CFG_DONE);
            end
         end
         step();
      end
      CFG_EN = 1'b0;
      tests_run++;
      if (CFG_DONE !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_done_rise: CFG_DONE=%b expected 1 after 40 shifts", tag, CFG_DONE);
      end
      tests_run++;
      if (CFG_DOUT !== vec[TOTAL-1]) begin
         tests_failed++;
         $display("FAIL %s_dout: CFG_DOUT=%b expected %b", tag, CFG_DOUT, vec[TOTAL-1]);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; CFG_EN = 1'b0; I = 8'h00;
      step(); step();
      tests_run++;
      if (CFG_DONE !== 1'b0 || CFG_DOUT !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_cfg: DONE=%b DOUT=%b expected 0 0", CFG_DONE, CFG_DOUT);
      end
      exp_q.push_back(2'b00);
      I = 8'hFF;
      #1;
      exp_o = exp_q.pop_front();
      tests_run++;
      if (O !== exp_o) begin
         tests_failed++;
         $display("FAIL reset_o: O=%b expected %b", O, exp_o);
      end
      RST = 1'b0;
      step();
      exp_q.push_back(2'b00);
      I = 8'h1F;
      step();
      exp_o = exp_q.pop_front();
      tests_run++;
      if (O !== exp_o) begin
         tests_failed++;
         $display("FAIL uncfg_o: O=%b expected %b", O, exp_o);
      end
   endtask

   task automatic test_comb();
      logic [3:0] nib_a [3] = '{4'hF, 4'hE, 4'h8};
      logic [1:0] ex_a  [3] = '{2'b01, 2'b00, 2'b00};
      I = 8'h00; CE = 2'b00; SR = 2'b00;
      load_stream(VEC2, -1, 0, "load2");
      for (int n = 0; n < 3; n++) begin
         exp_q.push_back(ex_a[n]);
         I[3:0] = nib_a[n];
         #1;
         exp_o = exp_q.pop_front();
         tests_run++;
         if (O !== exp_o) begin
            tests_failed++;
            $display("FAIL comb_%0h: O=%b expected %b", nib_a[n], O, exp_o);
         end
         step();
      end
   endtask

   task automatic test_registered();
      logic [3:0] nib_a [5] = '{4'h1, 4'h3, 4'h7, 4'h5, 4'h4};
      logic       ce_a  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       ex_a  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       prev;
      I = 8'h0F; CE = 2'b11; SR = 2'b00;
      step();
      prev = 1'b0;
      for (int n = 0; n < 5; n++) begin
         I[7:4] = nib_a[n];
         CE[1]  = ce_a[n];
         #1;
         tests_run++;
         if (O !== {prev, 1'b1}) begin
            tests_failed++;
            $display("FAIL reg_latency_%0d: O=%b expected %b", n, O, {prev, 1'b1});
         end
         exp_q.push_back({ex_a[n], 1'b1});
         step();
         exp_o = exp_q.pop_front();
         tests_run++;
         if (O !== exp_o) begin
            tests_failed++;
            $display("FAIL reg_%0d: O=%b expected %b", n, O, exp_o);
         end
         prev = ex_a[n];
      end
   endtask

   task automatic test_reset_polarity();
      logic [3:0] nib_a [11] = '{4'h1, 4'h1, 4'h3, 4'h7, 4'h0, 4'h3, 4'h5, 4'h6, 4'h9, 4'h7, 4'h8};
      logic       sr_a  [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       ce_a  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       ex_a  [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      RST = 1'b1; step(); RST = 1'b0;
      I = 8'h0F; CE = 2'b00; SR = 2'b00;
      load_stream(VEC4, -1, 0, "load4");
      for (int n = 0; n < 11; n++) begin
         exp_q.push_back({ex_a[n], 1'b1});
         I[7:4] = nib_a[n];
         SR[1]  = sr_a[n];
         CE[1]  = ce_a[n];
         step();
         exp_o = exp_q.pop_front();
         tests_run++;
         if (O !== exp_o) begin
            tests_failed++;
            $display("FAIL srpol_%0d: O=%b expected %b", n, O, exp_o);
         end
      end
   endtask

   task automatic test_paused_load();
      RST = 1'b1; step(); RST = 1'b0;
      I = 8'h1F; CE = 2'b00; SR = 2'b00;
      load_stream(VEC2, 20, 7, "pause");
      exp_q.push_back(2'b11);
      step();
      exp_o = exp_q.pop_front();
      tests_run++;
      if (O !== exp_o) begin
         tests_failed++;
         $display("FAIL pause_func: O=%b expected %b", O, exp_o);
      end
   endtask

   task automatic test_mid_load_reset();
      logic dout0;
      RST = 1'b1; step(); RST = 1'b0;
      I = 8'hFF; CE = 2'b00; SR = 2'b00;
      for (int j = 0; j < 25; j++) begin
         CFG_EN  = 1'b1;
         CFG_DIN = VEC2[TOTAL-1-j];
         step();
      end
      RST = 1'b1; CFG_DIN = 1'b1;
      step();
      RST = 1'b0; CFG_EN = 1'b0;
      tests_run++;
      if (CFG_DONE !== 1'b0 || CFG_DOUT !== 1'b0 || O !== 2'b00) begin
         tests_failed++;
         $display("FAIL midrst_clear: DONE=%b DOUT=%b O=%b expected 0 0 00", CFG_DONE, CFG_DOUT, O);
      end
      load_stream(VEC2, -1, 0, "reload");
      I = 8'h1F;
      step();
      dout0 = 1'b1;
      for (int n = 0; n < 10; n++) begin
         exp_q.push_back(2'b11);
         CFG_EN  = 1'b1;
         CFG_DIN = 1'($urandom_range(0, 1));
         step();
         exp_o = exp_q.pop_front();
         tests_run++;
         if (O !== exp_o || CFG_DOUT !== dout0) begin
            tests_failed++;
            $display("FAIL frozen_%0d: O=%b DOUT=%b expected %b %b", n, O, CFG_DOUT, exp_o, dout0);
         end
      end
      CFG_EN = 1'b0;
   endtask

   initial begin
      test_reset();
      test_comb();
      test_registered();
      test_reset_polarity();
      test_paused_load();
      test_mid_load_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
